// File: rtl/imem_boot_loader_if.sv
// Signal bundle between the boot loader and its UART, CPU fetch port and instruction memory.
// master is the loader side; slave is everything the loader talks to.
interface imem_boot_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic [31:0] cpu_pc;
  logic [31:0] imem_addr;
  logic        imem_we;
  logic [31:0] imem_wdata;
  logic        cpu_rst_n;
  logic        load_active;
  logic        load_error;

  modport master (
    input  rx_valid, rx_byte, tx_busy, cpu_pc,
    output tx_start, tx_byte, imem_addr, imem_we, imem_wdata,
           cpu_rst_n, load_active, load_error
  );

  modport slave (
    output rx_valid, rx_byte, tx_busy, cpu_pc,
    input  tx_start, tx_byte, imem_addr, imem_we, imem_wdata,
           cpu_rst_n, load_active, load_error
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Serial bootloader: receives a framed program image over UART, writes it into instruction
// memory while holding the CPU in reset, answers ACK/NAK, then hands the memory port to the CPU.
module imem_boot_loader #(
  parameter int ADDR_W       = 8,
  parameter int SYNC_TIMEOUT = 50000,
  parameter int BYTE_TIMEOUT = 20000
) (
  input  logic               clk,
  input  logic               rst_n,
  imem_boot_loader_if.master bus
);
  localparam int IDLE_W = $clog2(SYNC_TIMEOUT + 1);
  localparam int GAP_W  = $clog2(BYTE_TIMEOUT + 1);
  // Compared against the current count, so the step that would reach TIMEOUT-1 leaves instead.
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(SYNC_TIMEOUT - 2);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(BYTE_TIMEOUT - 2);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK       = 8'h06;
  localparam logic [7:0] NAK       = 8'h15;

  typedef enum logic [2:0] {
    WAIT_SYNC,
    GET_COUNT,
    GET_DATA,
    GET_CSUM,
    SEND_RESP,
    RUN
  } state_t;

  state_t            state_reg, state_next;
  logic [IDLE_W-1:0] idle_reg, idle_next;
  logic [GAP_W-1:0]  gap_reg, gap_next;
  logic [7:0]        csum_reg, csum_next;
  logic [1:0]        byte_idx_reg, byte_idx_next;
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [8:0]        words_left_reg, words_left_next;
  logic [23:0]       word_reg, word_next;
  logic [7:0]        resp_reg, resp_next;
  logic              tx_start_reg, tx_start_next;
  logic [7:0]        tx_byte_reg, tx_byte_next;
  logic              imem_we_reg, imem_we_next;
  logic [31:0]       imem_wdata_reg, imem_wdata_next;
  logic              cpu_rst_n_reg, cpu_rst_n_next;
  logic              load_error_reg, load_error_next;
  logic              load_active;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= WAIT_SYNC;
      idle_reg       <= '0;
      gap_reg        <= '0;
      csum_reg       <= '0;
      byte_idx_reg   <= '0;
      wr_ptr_reg     <= '0;
      words_left_reg <= '0;
      word_reg       <= '0;
      resp_reg       <= '0;
      tx_start_reg   <= 1'b0;
      tx_byte_reg    <= '0;
      imem_we_reg    <= 1'b0;
      imem_wdata_reg <= '0;
      cpu_rst_n_reg  <= 1'b0;
      load_error_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idle_reg       <= idle_next;
      gap_reg        <= gap_next;
      csum_reg       <= csum_next;
      byte_idx_reg   <= byte_idx_next;
      wr_ptr_reg     <= wr_ptr_next;
      words_left_reg <= words_left_next;
      word_reg       <= word_next;
      resp_reg       <= resp_next;
      tx_start_reg   <= tx_start_next;
      tx_byte_reg    <= tx_byte_next;
      imem_we_reg    <= imem_we_next;
      imem_wdata_reg <= imem_wdata_next;
      cpu_rst_n_reg  <= cpu_rst_n_next;
      load_error_reg <= load_error_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    idle_next       = idle_reg;
    gap_next        = gap_reg;
    csum_next       = csum_reg;
    byte_idx_next   = byte_idx_reg;
    wr_ptr_next     = wr_ptr_reg;
    words_left_next = words_left_reg;
    word_next       = word_reg;
    resp_next       = resp_reg;
    tx_byte_next    = tx_byte_reg;
    imem_wdata_next = imem_wdata_reg;
    load_error_next = load_error_reg;
    tx_start_next   = 1'b0;
    imem_we_next    = 1'b0;
    cpu_rst_n_next  = (state_reg == RUN);

    // The pointer advances only after the write cycle, so imem_addr shows the target during it.
    if (imem_we_reg) begin
      wr_ptr_next     = wr_ptr_reg + ADDR_W'(1);
      words_left_next = words_left_reg - 9'd1;
    end

    if (state_reg inside {GET_COUNT, GET_DATA, GET_CSUM}) begin
      if (bus.rx_valid) begin
        gap_next = '0;
      end else if (gap_reg == GAP_LAST) begin
        resp_next  = NAK;
        state_next = SEND_RESP;
      end else begin
        gap_next = gap_reg + GAP_W'(1);
      end
    end

    case (state_reg)
      WAIT_SYNC: begin
        if (bus.rx_valid) begin
          idle_next = '0;
          if (bus.rx_byte == SYNC_BYTE) begin
            state_next    = GET_COUNT;
            csum_next     = '0;
            byte_idx_next = '0;
            wr_ptr_next   = '0;
            gap_next      = '0;
          end
        end else if (idle_reg == IDLE_LAST) begin
          state_next = RUN;
        end else begin
          idle_next = idle_reg + IDLE_W'(1);
        end
      end
      GET_COUNT: begin
        if (bus.rx_valid) begin
          words_left_next = (bus.rx_byte == 8'd0) ? 9'd256 : {1'b0, bus.rx_byte};
          csum_next       = bus.rx_byte;
          state_next      = GET_DATA;
        end
      end
      GET_DATA: begin
        if (bus.rx_valid) begin
          word_next = {word_reg[15:0], bus.rx_byte};
          csum_next = csum_reg ^ bus.rx_byte;
          if (byte_idx_reg == 2'd3) begin
            byte_idx_next   = '0;
            imem_we_next    = 1'b1;
            imem_wdata_next = {word_reg, bus.rx_byte};
            // Leave on the last byte so a checksum arriving during the write is not taken as data.
            if (words_left_reg == 9'd1) begin
              state_next = GET_CSUM;
            end
          end else begin
            byte_idx_next = byte_idx_reg + 2'd1;
          end
        end
      end
      GET_CSUM: begin
        if (bus.rx_valid) begin
          resp_next  = (bus.rx_byte == csum_reg) ? ACK : NAK;
          state_next = SEND_RESP;
        end
      end
      SEND_RESP: begin
        if (!bus.tx_busy) begin
          tx_start_next = 1'b1;
          tx_byte_next  = resp_reg;
          if (resp_reg == ACK) begin
            load_error_next = 1'b0;
            state_next      = RUN;
          end else begin
            load_error_next = 1'b1;
            idle_next       = '0;
            state_next      = WAIT_SYNC;
          end
        end
      end
      RUN: begin
      end
      default: begin
        state_next = WAIT_SYNC;
      end
    endcase
  end

  assign load_active    = (state_reg != RUN);
  assign bus.load_active = load_active;
  assign bus.imem_addr  = load_active ? 32'(wr_ptr_reg) : bus.cpu_pc;
  assign bus.imem_we    = imem_we_reg;
  assign bus.imem_wdata = imem_wdata_reg;
  assign bus.tx_start   = tx_start_reg;
  assign bus.tx_byte    = tx_byte_reg;
  assign bus.cpu_rst_n  = cpu_rst_n_reg;
  assign bus.load_error = load_error_reg;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: frames are built from the wire-format rules,
// expected writes/responses are queued at send time and a monitor checks what the DUT emits.
module tb_imem_boot_loader;
  localparam int ADDR_W       = 8;
  localparam int SYNC_TIMEOUT = 400;
  localparam int BYTE_TIMEOUT = 60;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  logic clk = 1'b0;
  logic rst_n;

  imem_boot_loader_if bus();

  imem_boot_loader #(
    .ADDR_W(ADDR_W),
    .SYNC_TIMEOUT(SYNC_TIMEOUT),
    .BYTE_TIMEOUT(BYTE_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_rx_edge = 0;
  int          last_tx_cyc = 0;
  int          rel_cyc = 0;
  int          busy_mode = 0;
  int          edges;
  int          nwords;
  logic [7:0]  gbyte;
  logic [31:0] pc_drv = '0;
  logic        busy_drv = 1'b0;
  logic        mon_busy;
  logic [63:0] mon_wr;
  logic [7:0]  mon_tx;
  bit          exp_err = 1'b0;

  logic [63:0] exp_wr[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] frame_words[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // cpu_pc wanders every cycle; tx_busy is low, held high, or random depending on busy_mode.
  initial begin
    bus.tx_busy = 1'b0;
    bus.cpu_pc  = '0;
    forever begin
      @(negedge clk);
      pc_drv = $urandom;
      case (busy_mode)
        0:       busy_drv = 1'b0;
        1:       busy_drv = 1'b1;
        default: busy_drv = ($urandom_range(0, 3) == 0);
      endcase
      bus.cpu_pc  = pc_drv;
      bus.tx_busy = busy_drv;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT writes memory or starts a transmission.
  always @(posedge clk) begin
    mon_busy = busy_drv;
    #1;
    if (rst_n) begin
      if (bus.imem_we) begin
        if (exp_wr.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, required no write",
                   bus.imem_addr, bus.imem_wdata);
        end else begin
          mon_wr = exp_wr.pop_front();
          check("write_addr", bus.imem_addr, mon_wr[63:32]);
          check("write_data", bus.imem_wdata, mon_wr[31:0]);
          $display("write addr %0d data 0x%08h", bus.imem_addr, bus.imem_wdata);
        end
      end
      if (bus.tx_start) begin
        last_tx_cyc = cyc;
        check("tx_while_busy", 32'(mon_busy), 32'd0);
        if (exp_tx.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_tx: byte 0x%02h, required no transmission", bus.tx_byte);
        end else begin
          mon_tx = exp_tx.pop_front();
          check("tx_byte", 32'(bus.tx_byte), 32'(mon_tx));
          $display("resp 0x%02h at cycle %0d", bus.tx_byte, cyc);
        end
      end
      if (!bus.load_active) check("addr_mux", bus.imem_addr, pc_drv);
    end
  end

  task automatic do_reset();
    check("pending_writes", 32'(exp_wr.size()), 32'd0);
    check("pending_resp", 32'(exp_tx.size()), 32'd0);
    exp_wr.delete();
    exp_tx.delete();
    exp_err = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_tx_byte", 32'(bus.tx_byte), 32'd0);
    check("rst_imem_we", 32'(bus.imem_we), 32'd0);
    check("rst_imem_wdata", bus.imem_wdata, 32'd0);
    check("rst_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
    check("rst_load_error", 32'(bus.load_error), 32'd0);
    check("rst_load_active", 32'(bus.load_active), 32'd1);
    check("rst_imem_addr", bus.imem_addr, 32'd0);
    rst_n   = 1'b1;
    rel_cyc = cyc;
  endtask

  // Call just after a negedge; holds rx_valid for one cycle, then idles 0..gapmax cycles.
  task automatic send_byte(input logic [7:0] b, input int gapmax);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    last_rx_edge = cyc + 1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'($urandom);
    repeat ($urandom_range(0, gapmax)) @(negedge clk);
  endtask

  // Sends A5, count, big-endian words of frame_words, checksum; trunc>=0 stops after that many data bytes.
  task automatic send_frame(input int n, input bit corrupt, input int gapmax, input int trunc);
    logic [7:0]  cnt;
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [31:0] wd;
    int          sent;
    cnt  = 8'(n);
    cs   = cnt;
    sent = 0;
    send_byte(8'hA5, gapmax);
    send_byte(cnt, gapmax);
    for (int w = 0; w < n; w++) begin
      wd = frame_words[w];
      for (int k = 0; k < 4; k++) begin
        if (trunc >= 0 && sent == trunc) return;
        b  = 8'(wd >> (24 - 8 * k));
        cs = cs ^ b;
        if (k == 3) exp_wr.push_back({32'(w), wd});
        send_byte(b, gapmax);
        sent++;
      end
    end
    if (trunc >= 0) return;
    if (corrupt) cs = cs ^ 8'($urandom_range(1, 255));
    exp_tx.push_back(corrupt ? NAK : ACK);
    exp_err = corrupt;
    send_byte(cs, gapmax);
  endtask

  task automatic wait_resp(input int limit);
    int i;
    i = 0;
    while (exp_tx.size() != 0 && i < limit) begin
      @(posedge clk);
      i++;
    end
    if (exp_tx.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL resp_timeout: no tx_start within %0d cycles, required byte 0x%02h", limit, exp_tx[0]);
      exp_tx.delete();
    end
    repeat (3) @(negedge clk);
    check("load_error", 32'(bus.load_error), 32'(exp_err));
    check("cpu_rst_n", 32'(bus.cpu_rst_n), 32'(!exp_err));
    check("load_active", 32'(bus.load_active), 32'(exp_err));
  endtask

  task automatic wait_boot(output int e);
    e = -1;
    for (int i = 0; i < SYNC_TIMEOUT + 200; i++) begin
      @(posedge clk);
      #1;
      if (bus.cpu_rst_n) begin
        e = cyc - rel_cyc;
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = '0;
    do_reset();

    // No traffic: the resident image boots after exactly SYNC_TIMEOUT cycles.
    wait_boot(edges);
    check("boot_cycles", 32'(edges), 32'(SYNC_TIMEOUT));
    check("boot_load_error", 32'(bus.load_error), 32'd0);
    check("boot_no_tx", 32'(bus.tx_byte), 32'd0);
    repeat (20) @(negedge clk);

    // Two-word frame, then a corrupted copy, then recovery.
    do_reset();
    frame_words = '{32'h2001_0001, 32'h0001_1020};
    send_frame(2, 1'b0, 2, -1);
    wait_resp(500);
    do_reset();
    send_frame(2, 1'b1, 2, -1);
    wait_resp(500);
    send_frame(2, 1'b0, 0, -1);
    wait_resp(500);

    // Transmitter busy across the response slot.
    do_reset();
    busy_mode = 1;
    send_frame(2, 1'b0, 1, -1);
    repeat (100) @(negedge clk);
    check("resp_held_by_busy", 32'(exp_tx.size()), 32'd1);
    busy_mode = 0;
    wait_resp(50);

    // Truncated frame A5 01 20 01 then silence.
    do_reset();
    frame_words = '{32'h2001_0000};
    send_frame(1, 1'b0, 0, 2);
    exp_tx.push_back(NAK);
    exp_err = 1'b1;
    wait_resp(BYTE_TIMEOUT + 20);
    check("nak_latency", 32'(last_tx_cyc - last_rx_edge), 32'(BYTE_TIMEOUT));
    wait_boot(edges);
    check("boot_after_nak", 32'(bus.cpu_rst_n), 32'd1);
    check("error_kept_after_boot", 32'(bus.load_error), 32'd1);

    // Random frames with leading garbage, random checksums and random tx_busy.
    busy_mode = 2;
    for (int t = 0; t < 6; t++) begin
      do_reset();
      frame_words.delete();
      nwords = $urandom_range(1, 8);
      for (int i = 0; i < nwords; i++) frame_words.push_back($urandom);
      repeat ($urandom_range(0, 3)) begin
        gbyte = 8'($urandom);
        if (gbyte == 8'hA5) gbyte = 8'h5A;
        send_byte(gbyte, 2);
      end
      send_frame(nwords, ($urandom_range(0, 2) == 0), 3, -1);
      wait_resp(500);
    end
    busy_mode = 0;

    // Full 256-word image (count byte 0) after garbage.
    do_reset();
    frame_words.delete();
    for (int i = 0; i < 256; i++) frame_words.push_back($urandom);
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    send_frame(256, 1'b0, 1, -1);
    wait_resp(500);

    // Reset in the middle of a load, then a fresh short load.
    do_reset();
    send_frame(256, 1'b0, 1, 22);
    repeat (3) @(negedge clk);
    do_reset();
    send_frame(3, 1'b0, 2, -1);
    wait_resp(500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
